// File: rtl/fir_reg_bank_pkg.sv
// rtl/fir_reg_bank_pkg.sv - register map, bit positions and FSM state type for the FIR register bank
package fir_pkg;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_STATUS    = 6'h01;
  localparam logic [5:0] ADDR_NSAMPLES  = 6'h02;
  localparam logic [5:0] ADDR_SCOUNT    = 6'h03;
  localparam logic [5:0] ADDR_COEF_BASE = 6'h20;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fir_state_t;

endpackage

// File: rtl/fir_reg_bank_if.sv
// rtl/fir_reg_bank_if.sv - register bus between the APB bridge and the FIR register bank
interface fir_reg_bank_if #(
  parameter int DW = 16
);
  logic [5:0]    p_address;
  logic [DW-1:0] p_data;
  logic          p_wr;
  logic [DW-1:0] p_data_back;

  modport master (output p_address, output p_data, output p_wr, input p_data_back);
  modport slave  (input p_address, input p_data, input p_wr, output p_data_back);
endinterface

// File: rtl/fir_reg_bank_coef.sv
// rtl/fir_reg_bank_coef.sv - NCOEF x DW coefficient store, one write port and two combinational read ports
module fir_coef_bank #(
  parameter int NCOEF = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NCOEF)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NCOEF)-1:0] raddr,
  output logic [DW-1:0]            rdata,
  input  logic [$clog2(NCOEF)-1:0] cidx,
  output logic [DW-1:0]            cdata
);
  logic [DW-1:0] mem [NCOEF];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign cdata = mem[cidx];
endmodule

// File: rtl/fir_reg_bank.sv
// rtl/fir_reg_bank.sv - control/status/coefficient register bank with run FSM for a FIR core
module fir_reg_bank
  import fir_pkg::*;
#(
  parameter int NCOEF = 16,
  parameter int DW    = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  fir_reg_bank_if.slave            bus,
  input  logic [$clog2(NCOEF)-1:0] coef_idx,
  output logic [DW-1:0]            coef_data,
  output logic                     fir_start,
  output logic                     fir_abort,
  output logic [15:0]              fir_nsamples,
  input  logic                     fir_sample_valid,
  output logic                     irq
);
  localparam int IW = $clog2(NCOEF);

  fir_state_t    state_q, state_d;
  logic          irq_en_q, done_q, err_q, start_q, abort_q;
  logic [15:0]   nsamples_q, scount_q;
  logic [DW-1:0] coef_rd, rd_data;
  logic          wr_ctrl, wr_status, wr_nsamp, wr_coef, coef_hit;
  logic          start_req, abort_req;
  logic          start_ok, abort_ok, count_en, done_set, err_set;

  assign coef_hit  = bus.p_address[5] && (int'(bus.p_address[4:0]) < NCOEF);
  assign wr_ctrl   = bus.p_wr && (bus.p_address == ADDR_CTRL);
  assign wr_status = bus.p_wr && (bus.p_address == ADDR_STATUS);
  assign wr_nsamp  = bus.p_wr && (bus.p_address == ADDR_NSAMPLES);
  assign wr_coef   = bus.p_wr && coef_hit;

  // ABORT in the same write masks START entirely
  assign abort_req = wr_ctrl && bus.p_data[CTRL_ABORT];
  assign start_req = wr_ctrl && bus.p_data[CTRL_START] && !bus.p_data[CTRL_ABORT];

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    abort_ok = 1'b0;
    count_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start_req) begin
        if (nsamples_q != 16'd0) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
        end else begin
          err_set = 1'b1;
        end
      end
    end else begin
      if (start_req || wr_nsamp || wr_coef) err_set = 1'b1;
      if (abort_req) begin
        abort_ok = 1'b1;
        state_d  = ST_IDLE;
      end else if (fir_sample_valid) begin
        count_en = 1'b1;
        if (scount_q + 16'd1 == nsamples_q) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      nsamples_q <= '0;
      scount_q   <= '0;
    end else begin
      start_q <= start_ok;
      abort_q <= abort_ok;
      if (wr_ctrl) irq_en_q <= bus.p_data[CTRL_IRQ_EN];
      if (wr_nsamp && state_q == ST_IDLE) nsamples_q <= 16'(bus.p_data);
      if (start_ok)      scount_q <= '0;
      else if (count_en) scount_q <= scount_q + 16'd1;
      // a set event in the same cycle as its W1C clear keeps the bit set
      done_q <= done_set || (done_q && !(wr_status && bus.p_data[STAT_DONE]));
      err_q  <= err_set  || (err_q  && !(wr_status && bus.p_data[STAT_ERR]));
    end
  end

  fir_coef_bank #(.NCOEF(NCOEF), .DW(DW)) u_coef (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (wr_coef && state_q == ST_IDLE),
    .waddr (bus.p_address[IW-1:0]),
    .wdata (bus.p_data),
    .raddr (bus.p_address[IW-1:0]),
    .rdata (coef_rd),
    .cidx  (coef_idx),
    .cdata (coef_data)
  );

  always_comb begin
    rd_data = '0;
    if (coef_hit) begin
      rd_data = coef_rd;
    end else begin
      case (bus.p_address)
        ADDR_CTRL:     rd_data[CTRL_IRQ_EN] = irq_en_q;
        ADDR_STATUS: begin
          rd_data[STAT_BUSY] = (state_q == ST_RUN);
          rd_data[STAT_DONE] = done_q;
          rd_data[STAT_ERR]  = err_q;
        end
        ADDR_NSAMPLES: rd_data = DW'(nsamples_q);
        ADDR_SCOUNT:   rd_data = DW'(scount_q);
        default:       rd_data = '0;
      endcase
    end
  end

  assign bus.p_data_back = rd_data;
  assign fir_start       = start_q;
  assign fir_abort       = abort_q;
  assign fir_nsamples    = nsamples_q;
  assign irq             = done_q && irq_en_q;
endmodule

// File: tb/tb_fir_reg_bank.sv
// tb/tb_fir_reg_bank.sv - self-checking bench for fir_reg_bank: vector table, corner sequences, random vs model
module tb_fir_reg_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  coef_idx = '0;
  logic [15:0] coef_data;
  logic        fir_start, fir_abort, irq, fir_sample_valid = 1'b0;
  logic [15:0] fir_nsamples;

  fir_reg_bank_if #(.DW(16)) bus ();

  fir_reg_bank #(.NCOEF(16), .DW(16)) dut (
    .PCLK             (clk),
    .PRESET           (rst),
    .bus              (bus),
    .coef_idx         (coef_idx),
    .coef_data        (coef_data),
    .fir_start        (fir_start),
    .fir_abort        (fir_abort),
    .fir_nsamples     (fir_nsamples),
    .fir_sample_valid (fir_sample_valid),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model of the programmer-visible state
  bit          m_run, m_done, m_err, m_irq_en, m_start, m_abort;
  int          m_nsamp, m_scount;
  logic [15:0] m_coef [16];

  typedef struct {
    logic        wr;
    logic [5:0]  a;
    logic [15:0] d;
    logic        sv;
    logic        e_start;
    logic        e_abort;
    logic        e_irq;
    logic [15:0] e_status;
    logic [15:0] e_scount;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_irq_en = 0; m_start = 0; m_abort = 0;
    m_nsamp = 0; m_scount = 0;
    for (int i = 0; i < 16; i++) m_coef[i] = '0;
  endtask

  task automatic model_update(input logic wr, input logic [5:0] a, input logic [15:0] d, input logic sv);
    bit was_run, ab, st, aborted;
    was_run = m_run; m_start = 0; m_abort = 0; aborted = 0;
    if (wr && a == 6'h01) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end
    if (wr && a == 6'h00) begin
      m_irq_en = d[1];
      ab = d[2];
      st = d[0] && !d[2];
      if (ab && was_run) begin m_run = 0; m_abort = 1; aborted = 1; end
      if (st) begin
        if (was_run || m_nsamp == 0) m_err = 1;
        else begin m_run = 1; m_scount = 0; m_start = 1; end
      end
    end
    if (wr && a == 6'h02) begin
      if (was_run) m_err = 1; else m_nsamp = d;
    end
    if (wr && a >= 6'h20 && a < 6'h30) begin
      if (was_run) m_err = 1; else m_coef[a - 6'h20] = d;
    end
    if (sv && was_run && !aborted) begin
      m_scount++;
      if (m_scount == m_nsamp) begin m_run = 0; m_done = 1; end
    end
  endtask

  task automatic step(input logic wr, input logic [5:0] a, input logic [15:0] d, input logic sv);
    @(negedge clk);
    bus.p_wr = wr; bus.p_address = a; bus.p_data = d; fir_sample_valid = sv;
    @(posedge clk);
    model_update(wr, a, d, sv);
    #1;
    bus.p_wr = 1'b0; fir_sample_valid = 1'b0;
    chk("fir_start", fir_start, m_start);
    chk("fir_abort", fir_abort, m_abort);
    chk("irq", irq, m_done && m_irq_en);
  endtask

  task automatic rd(input logic [5:0] a, input string nm, input logic [15:0] exp);
    bus.p_address = a;
    #1;
    chk(nm, bus.p_data_back, exp);
  endtask

  task automatic model_check();
    int k;
    rd(6'h00, "CTRL", {13'd0, 1'b0, m_irq_en, 1'b0});
    rd(6'h01, "STATUS", {13'd0, m_err, m_done, m_run});
    rd(6'h02, "NSAMPLES", 16'(m_nsamp));
    rd(6'h03, "SCOUNT", 16'(m_scount));
    chk("fir_nsamples", fir_nsamples, 16'(m_nsamp));
    k = $urandom_range(0, 15);
    coef_idx = 4'(k);
    rd(6'(6'h20 + k), "COEF_rd", m_coef[k]);
    chk("coef_data", coef_data, m_coef[k]);
  endtask

  initial begin
    bus.p_wr = 1'b0; bus.p_address = '0; bus.p_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_fir_start", fir_start, 1'b0);
    chk("rst_irq", irq, 1'b0);
    model_check();

    //        wr  addr   data      sv  start abort irq status scount
    vecs.push_back('{1, 6'h02, 16'h0004, 0, 0, 0, 0, 16'h0, 16'd0});
    vecs.push_back('{1, 6'h00, 16'h0003, 0, 1, 0, 0, 16'h1, 16'd0});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h1, 16'd1});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h1, 16'd2});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h1, 16'd3});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 1, 16'h2, 16'd4});
    vecs.push_back('{1, 6'h01, 16'h0002, 0, 0, 0, 0, 16'h0, 16'd4});
    vecs.push_back('{1, 6'h02, 16'h0000, 0, 0, 0, 0, 16'h0, 16'd4});
    vecs.push_back('{1, 6'h00, 16'h0001, 0, 0, 0, 0, 16'h4, 16'd4});
    vecs.push_back('{1, 6'h01, 16'h0004, 0, 0, 0, 0, 16'h0, 16'd4});
    vecs.push_back('{1, 6'h02, 16'h000A, 0, 0, 0, 0, 16'h0, 16'd4});
    vecs.push_back('{1, 6'h00, 16'h0001, 0, 1, 0, 0, 16'h1, 16'd0});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h1, 16'd1});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h1, 16'd2});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h1, 16'd3});
    vecs.push_back('{1, 6'h00, 16'h0004, 0, 0, 1, 0, 16'h0, 16'd3});
    vecs.push_back('{1, 6'h00, 16'h0004, 0, 0, 0, 0, 16'h0, 16'd3});
    vecs.push_back('{1, 6'h00, 16'h0005, 0, 0, 0, 0, 16'h0, 16'd3});
    vecs.push_back('{0, 6'h00, 16'h0000, 1, 0, 0, 0, 16'h0, 16'd3});
    vecs.push_back('{1, 6'h3F, 16'hFFFF, 0, 0, 0, 0, 16'h0, 16'd3});
    vecs.push_back('{1, 6'h03, 16'h0007, 0, 0, 0, 0, 16'h0, 16'd3});

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].sv);
      chk($sformatf("v%0d_start", i), fir_start, vecs[i].e_start);
      chk($sformatf("v%0d_abort", i), fir_abort, vecs[i].e_abort);
      chk($sformatf("v%0d_irq", i), irq, vecs[i].e_irq);
      rd(6'h01, $sformatf("v%0d_status", i), vecs[i].e_status);
      rd(6'h03, $sformatf("v%0d_scount", i), vecs[i].e_scount);
    end

    // coefficient write and readback on both ports
    step(1, 6'h23, 16'h1234, 0);
    rd(6'h23, "coef3_rd", 16'h1234);
    coef_idx = 4'd3; #1;
    chk("coef3_port", coef_data, 16'h1234);

    // COEF write during RUN is rejected; final pulse beats a coincident DONE clear
    step(1, 6'h02, 16'h0002, 0);
    step(1, 6'h00, 16'h0001, 0);
    step(1, 6'h20, 16'hFFFF, 0);
    rd(6'h20, "coef0_locked", 16'h0000);
    rd(6'h01, "err_on_coef_run", 16'h0005);
    step(0, 6'h00, 16'h0000, 1);
    step(1, 6'h01, 16'h0006, 1);
    rd(6'h01, "done_beats_w1c", 16'h0002);
    rd(6'h03, "scount_final", 16'd2);

    // reset during RUN clears everything without an abort pulse
    step(1, 6'h02, 16'h0005, 0);
    step(1, 6'h00, 16'h0003, 0);
    step(0, 6'h00, 16'h0000, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("prst_fir_abort", fir_abort, 1'b0);
    chk("prst_fir_start", fir_start, 1'b0);
    chk("prst_irq", irq, 1'b0);
    model_check();
    rd(6'h23, "prst_coef3", 16'h0000);
    @(posedge clk); #1;
    chk("prst_no_late_abort", fir_abort, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [15:0] d;
      logic [5:0]  a;
      sel = $urandom_range(0, 9);
      d = 16'($urandom);
      case (sel)
        0, 1: begin a = 6'h00; d[2] = ($urandom_range(0, 5) == 0); d[0] = ($urandom_range(0, 2) != 0); end
        2:    a = 6'h01;
        3:    begin a = 6'h02; d = 16'($urandom_range(0, 4)); end
        4:    a = 6'(6'h20 + $urandom_range(0, 31));
        5:    a = 6'($urandom);
        default: a = 6'h00;
      endcase
      if (sel >= 6) step(0, a, d, $urandom_range(0, 3) != 0);
      else          step(1, a, d, $urandom_range(0, 3) == 0);
      model_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
